slave_ram_frame_reader: RTL and testbench
=========================================

# slave_ram_frame_reader

Read-side sequencer for the slave dual-port block RAM. On a start pulse it reads a contiguous block of 32-bit words through the RAM's registered read port and streams them out on a valid/ready interface with a last-beat marker and a running 32-bit checksum. It sits between the slave RAM read port and the frame transmitter. It absorbs the RAM's 1-cycle read latency and downstream backpressure without losing or duplicating words.

## Interface
Parameters:
- ADDR_WIDTH, 8, RAM address width (256 words)
- DATA_WIDTH, 32, RAM word width

Ports:
- i_clk  in  1  system clock; all logic on rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_start  in  1  one-cycle start pulse; ignored while o_busy=1
- i_base_addr  in  ADDR_WIDTH  first word address, sampled with i_start
- i_word_cnt  in  ADDR_WIDTH+1  words to send, sampled with i_start; 0 = empty frame; values >256 clamp to 256
- o_busy  out  1  frame in progress
- o_done  out  1  one-cycle pulse at frame end
- o_slave_r_ram_addr  out  ADDR_WIDTH  RAM read address
- o_slave_r_ram_ce  out  1  RAM read enable
- i_slave_r_ram_dout  in  DATA_WIDTH  RAM read data; valid 1 cycle after ce and held while ce=0
- o_tx_data  out  DATA_WIDTH  stream data
- o_tx_valid  out  1  stream valid
- o_tx_last  out  1  final beat of frame
- i_tx_ready  in  1  downstream accept
- o_checksum  out  DATA_WIDTH  sum of sent words mod 2^32

## Operation
- FSM states:
  - IDLE: start → READ, or DONE if the clamped count is 0
  - READ: all reads issued → DRAIN
  - DRAIN: final handshake → DONE
  - DONE: → IDLE after 1 cycle; o_done=1 in this cycle
- On accepted start: latch base/count, clear checksum, clear issue and send counters.
- Read issue in READ: ce=1 when (buffer occupancy + in-flight − pop this cycle) < 2 and issued < count.
  - Each issue increments the address mod 256, so the frame wraps 0xFF → 0x00.
- In-flight flag is set the cycle after ce and pushes dout into a 2-entry FIFO; o_tx_* is driven from the FIFO head.
- Handshake = o_tx_valid & i_tx_ready. On each handshake: checksum += o_tx_data (wrapping), sent++.
- o_tx_last = 1 on the head beat when sent == count−1.
- While o_tx_valid=1 and i_tx_ready=0: o_tx_data and o_tx_last held stable; valid never drops.
- o_checksum holds its final value from o_done until the next accepted start.
- No read is ever issued beyond count, and no word is emitted twice.

## Timing
- Reset values:
  - all outputs 0
  - FSM in IDLE
  - FIFO empty
  - counters and checksum 0
- Reset is asynchronous; assertion mid-frame aborts immediately with no done pulse.
- Start accepted in cycle 0:
  - o_busy=1 from cycle 1
  - first ce in cycle 1
  - first o_tx_valid in cycle 3
- With i_tx_ready held high: 1 beat/cycle, no bubbles; a count-N frame has beats in cycles 3..N+2 and o_done in cycle N+3.
- Count 0: o_done in cycle 1; no ce, no valid.
- o_busy falls in the same cycle o_done is asserted; a new start is accepted from the following cycle.
- i_start during a busy frame: no effect.

## Structure
- Shared package slave_ram_pkg: ADDR_WIDTH, DATA_WIDTH, frame-reader state enum (IDLE, READ, DRAIN, DONE).
- Sub-module slave_ram_rd_fifo2: 2-entry FIFO with push, pop, occupancy and head outputs; async active-low reset.
- Top holds the FSM, counters, address generator, and checksum.

## Test plan
- RAM[0x10..0x13] = 1,2,3,4; start with base 0x10, count 4, ready=1 → data 1,2,3,4 in cycles 3–6; last on 4; done in cycle 7; checksum 0x0000000A.
- Base 0xFE, count 4 → ce addresses 0xFE, 0xFF, 0x00, 0x01; 4 beats; last on the 4th.
- Count 8 with ready low for cycles 4–9 → data held stable while stalled; exactly 8 ce pulses and 8 distinct in-order beats; no loss.
- Count 0 → done in cycle 1, no valid, checksum 0. Count 300 → exactly 256 beats, last on beat 256.
- Start pulsed mid-frame → ignored, frame completes unchanged. Reset asserted mid-frame → all outputs 0 immediately; a following start with count 2 completes normally.
- Words 0xFFFFFFFF, 0x00000002 → checksum 0x00000001.

Source files
------------

// File: rtl/slave_ram_pkg.sv
// Shared definitions for the slave dual-port RAM read path.
package slave_ram_pkg;
  localparam int ADDR_WIDTH = 8;
  localparam int DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } rd_state_t;
endpackage

// File: rtl/slave_ram_rd_fifo2.sv
// Two-entry skid FIFO catching RAM read data so downstream stalls never lose a word.
module slave_ram_rd_fifo2 #(
  parameter int DATA_WIDTH = slave_ram_pkg::DATA_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_push,
  input  logic [DATA_WIDTH-1:0] i_din,
  input  logic                  i_pop,
  output logic [1:0]            o_count,
  output logic [DATA_WIDTH-1:0] o_head
);
  logic [1:0][DATA_WIDTH-1:0] mem;
  logic                       rd_ptr;
  logic                       wr_ptr;
  logic [1:0]                 count;
  logic                       do_pop;
  logic                       do_push;

  // Pop only real entries; push into a full FIFO only when a pop frees a slot.
  assign do_pop  = i_pop & (count != 2'd0);
  assign do_push = i_push & ((count != 2'd2) | do_pop);

  // Storage, pointers and occupancy.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mem    <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= i_din;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  assign o_count = count;
  assign o_head  = mem[rd_ptr];
endmodule

// File: rtl/slave_ram_frame_reader.sv
// Streams a contiguous block of slave RAM words out on valid/ready with last and checksum.
module slave_ram_frame_reader #(
  parameter int ADDR_WIDTH = slave_ram_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = slave_ram_pkg::DATA_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_base_addr,
  input  logic [ADDR_WIDTH:0]   i_word_cnt,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [ADDR_WIDTH-1:0] o_slave_r_ram_addr,
  output logic                  o_slave_r_ram_ce,
  input  logic [DATA_WIDTH-1:0] i_slave_r_ram_dout,
  output logic [DATA_WIDTH-1:0] o_tx_data,
  output logic                  o_tx_valid,
  output logic                  o_tx_last,
  input  logic                  i_tx_ready,
  output logic [DATA_WIDTH-1:0] o_checksum
);
  import slave_ram_pkg::*;

  localparam logic [ADDR_WIDTH:0] MAX_WORDS = {1'b1, {ADDR_WIDTH{1'b0}}};

  rd_state_t               state;
  logic [ADDR_WIDTH-1:0]   rd_addr;
  logic [ADDR_WIDTH:0]     word_cnt;
  logic [ADDR_WIDTH:0]     issued;
  logic [ADDR_WIDTH:0]     sent;
  logic                    in_flight;
  logic [DATA_WIDTH-1:0]   checksum;
  logic [ADDR_WIDTH:0]     cnt_clamped;
  logic [1:0]              fifo_cnt;
  logic [DATA_WIDTH-1:0]   fifo_head;
  logic [2:0]              occ_after;
  logic                    tx_valid;
  logic                    hs;
  logic                    issue;
  logic                    last_beat;

  assign cnt_clamped = (i_word_cnt > MAX_WORDS) ? MAX_WORDS : i_word_cnt;

  assign tx_valid  = (fifo_cnt != 2'd0);
  assign hs        = tx_valid & i_tx_ready;
  assign last_beat = tx_valid & (sent == word_cnt - 1'b1);

  // Slots committed after this cycle: buffered plus the word landing next, minus the pop now.
  assign occ_after = {1'b0, fifo_cnt} + {2'b0, in_flight} - {2'b0, hs};
  assign issue     = (state == READ) & (issued != word_cnt) & (occ_after < 3'd2);

  slave_ram_rd_fifo2 #(.DATA_WIDTH(DATA_WIDTH)) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (in_flight),
    .i_din   (i_slave_r_ram_dout),
    .i_pop   (hs),
    .o_count (fifo_cnt),
    .o_head  (fifo_head)
  );

  // Frame sequencer: start latch, read issue, beat accounting and checksum.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= IDLE;
      rd_addr   <= '0;
      word_cnt  <= '0;
      issued    <= '0;
      sent      <= '0;
      in_flight <= 1'b0;
      checksum  <= '0;
    end else begin
      in_flight <= issue;
      if (hs) begin
        checksum <= checksum + fifo_head;
        sent     <= sent + 1'b1;
      end
      if (issue) begin
        rd_addr <= rd_addr + 1'b1;
        issued  <= issued + 1'b1;
      end
      case (state)
        IDLE: begin
          if (i_start) begin
            rd_addr  <= i_base_addr;
            word_cnt <= cnt_clamped;
            issued   <= '0;
            sent     <= '0;
            checksum <= '0;
            state    <= (cnt_clamped == '0) ? DONE : READ;
          end
        end
        READ: begin
          if (issue && (issued == word_cnt - 1'b1)) state <= DRAIN;
        end
        DRAIN: begin
          if (hs && last_beat) state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign o_busy             = (state == READ) | (state == DRAIN);
  assign o_done             = (state == DONE);
  assign o_slave_r_ram_addr = rd_addr;
  assign o_slave_r_ram_ce   = issue;
  assign o_tx_data          = fifo_head;
  assign o_tx_valid         = tx_valid;
  assign o_tx_last          = last_beat;
  assign o_checksum         = checksum;
endmodule

// File: tb/tb_slave_ram_frame_reader.sv
// Directed bench for slave_ram_frame_reader with a registered-read RAM model.
module tb_slave_ram_frame_reader;
  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_start = 1'b0;
  logic [7:0]  i_base_addr = '0;
  logic [8:0]  i_word_cnt = '0;
  logic        o_busy, o_done;
  logic [7:0]  o_slave_r_ram_addr;
  logic        o_slave_r_ram_ce;
  logic [31:0] i_slave_r_ram_dout = '0;
  logic [31:0] o_tx_data;
  logic        o_tx_valid, o_tx_last;
  logic        i_tx_ready = 1'b1;
  logic [31:0] o_checksum;

  logic [31:0] ram [256];

  int checks = 0;
  int errors = 0;

  logic [31:0] bdata [$];
  int          bcyc  [$];
  logic        blast [$];
  logic [7:0]  ce_addr [$];
  int          done_rel, first_valid, stall_err;
  logic        busy1;

  slave_ram_frame_reader dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_base_addr(i_base_addr),
    .i_word_cnt(i_word_cnt), .o_busy(o_busy), .o_done(o_done),
    .o_slave_r_ram_addr(o_slave_r_ram_addr), .o_slave_r_ram_ce(o_slave_r_ram_ce),
    .i_slave_r_ram_dout(i_slave_r_ram_dout), .o_tx_data(o_tx_data), .o_tx_valid(o_tx_valid),
    .o_tx_last(o_tx_last), .i_tx_ready(i_tx_ready), .o_checksum(o_checksum)
  );

  always #5 i_clk = ~i_clk;

  // Registered read port: data appears the cycle after ce and holds otherwise.
  always @(posedge i_clk) if (o_slave_r_ram_ce) i_slave_r_ram_dout <= ram[o_slave_r_ram_addr];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Runs one frame starting in the current cycle (cycle 0). Ready is low in cycles slo..shi.
  // mid_k > 0 pulses a second start with different parameters in that cycle.
  task automatic run_frame(input logic [7:0] base, input logic [8:0] cnt,
                           input int slo, input int shi, input int mid_k);
    logic        held_v;
    logic [31:0] held_d;
    logic        held_l;
    bdata.delete(); bcyc.delete(); blast.delete(); ce_addr.delete();
    done_rel = -1; first_valid = -1; stall_err = 0; busy1 = 1'b0; held_v = 1'b0;
    held_d = '0; held_l = 1'b0;
    i_base_addr = base; i_word_cnt = cnt; i_start = 1'b1;
    for (int k = 0; k < 1000 && done_rel < 0; k++) begin
      if (k > 0) begin
        @(posedge i_clk); #1;
        i_start = (k == mid_k);
        if (k == mid_k) begin i_base_addr = 8'h50; i_word_cnt = 9'd9; end
      end
      i_tx_ready = !(k >= slo && k <= shi);
      @(negedge i_clk);
      if (k == 1) busy1 = o_busy;
      if (o_slave_r_ram_ce) ce_addr.push_back(o_slave_r_ram_addr);
      if (held_v && (!o_tx_valid || o_tx_data !== held_d || o_tx_last !== held_l)) stall_err++;
      held_v = o_tx_valid && !i_tx_ready;
      held_d = o_tx_data;
      held_l = o_tx_last;
      if (o_tx_valid) begin
        if (first_valid < 0) first_valid = k;
        if (i_tx_ready) begin
          bdata.push_back(o_tx_data); bcyc.push_back(k); blast.push_back(o_tx_last);
        end
      end
      if (o_done) done_rel = k;
    end
    i_start = 1'b0; i_tx_ready = 1'b1;
    @(posedge i_clk); #1;
  endtask

  initial begin
    logic [31:0] sum;
    int          nlast;
    int          bad;
    for (int i = 0; i < 256; i++) ram[i] = 32'h1000_0000 + i * 32'h0001_0003;
    ram[8'h10] = 32'd1; ram[8'h11] = 32'd2; ram[8'h12] = 32'd3; ram[8'h13] = 32'd4;
    ram[8'h30] = 32'hFFFF_FFFF; ram[8'h31] = 32'h0000_0002;

    // Reset state
    repeat (3) @(posedge i_clk);
    #1;
    check("reset_outputs", {o_busy, o_done, o_slave_r_ram_ce, o_slave_r_ram_addr, o_tx_valid,
                            o_tx_last, o_tx_data, o_checksum}, 64'd0);
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;

    // Basic 4-word frame
    run_frame(8'h10, 9'd4, -1, -1, -1);
    check("t1_busy_c1", busy1, 1);
    check("t1_first_ce", ce_addr.size() > 0 ? ce_addr[0] : 8'hxx, 8'h10);
    check("t1_beats", bdata.size(), 4);
    for (int i = 0; i < 4; i++) begin
      check("t1_data", bdata[i], i + 1);
      check("t1_cycle", bcyc[i], i + 3);
      check("t1_last", blast[i], i == 3);
    end
    check("t1_done_cycle", done_rel, 7);
    check("t1_checksum", o_checksum, 32'h0000_000A);
    repeat (2) @(posedge i_clk);
    #1;
    check("t1_checksum_hold", o_checksum, 32'h0000_000A);
    check("t1_idle_flags", {o_busy, o_done, o_tx_valid}, 3'b000);

    // Address wrap 0xFE -> 0x01
    ram[8'hFE] = 32'h11; ram[8'hFF] = 32'h22; ram[8'h00] = 32'h33; ram[8'h01] = 32'h44;
    run_frame(8'hFE, 9'd4, -1, -1, -1);
    check("t2_ce_count", ce_addr.size(), 4);
    check("t2_ce_addrs", {ce_addr[0], ce_addr[1], ce_addr[2], ce_addr[3]}, 32'hFEFF_0001);
    check("t2_beats", bdata.size(), 4);
    check("t2_data", {bdata[0][7:0], bdata[1][7:0], bdata[2][7:0], bdata[3][7:0]}, 32'h1122_3344);
    check("t2_last", {blast[3], blast[2], blast[1], blast[0]}, 4'b1000);

    // Backpressure: ready low in cycles 4..9
    for (int i = 0; i < 8; i++) ram[8'h20 + i] = 32'h100 + i;
    run_frame(8'h20, 9'd8, 4, 9, -1);
    check("t3_done_seen", done_rel > 0, 1);
    check("t3_ce_count", ce_addr.size(), 8);
    check("t3_beats", bdata.size(), 8);
    bad = 0;
    for (int i = 0; i < 8; i++) if (bdata[i] !== 32'h100 + i || blast[i] !== (i == 7)) bad++;
    check("t3_order_last", bad, 0);
    check("t3_stall_stable", stall_err, 0);
    check("t3_checksum", o_checksum, 32'h0000_081C);

    // Empty frame
    run_frame(8'h40, 9'd0, -1, -1, -1);
    check("t4_done_cycle", done_rel, 1);
    check("t4_no_valid", first_valid, -1);
    check("t4_no_ce", ce_addr.size(), 0);
    check("t4_checksum", o_checksum, 32'd0);

    // Oversize count clamps to 256
    ram[8'hFE] = 32'h11; ram[8'hFF] = 32'h22; ram[8'h00] = 32'h33; ram[8'h01] = 32'h44;
    sum = '0;
    for (int i = 0; i < 256; i++) sum += ram[i];
    run_frame(8'h00, 9'd300, -1, -1, -1);
    check("t5_ce_count", ce_addr.size(), 256);
    check("t5_beats", bdata.size(), 256);
    nlast = 0;
    foreach (blast[i]) if (blast[i]) nlast++;
    check("t5_last_count", nlast, 1);
    check("t5_last_pos", blast[255], 1);
    check("t5_done_cycle", done_rel, 259);
    check("t5_checksum", o_checksum, sum);

    // Start pulsed mid-frame is ignored
    run_frame(8'h10, 9'd4, -1, -1, 2);
    check("t6_beats", bdata.size(), 4);
    check("t6_data", {bdata[0][7:0], bdata[1][7:0], bdata[2][7:0], bdata[3][7:0]}, 32'h0102_0304);
    check("t6_done_cycle", done_rel, 7);
    check("t6_checksum", o_checksum, 32'h0000_000A);

    // Reset mid-frame
    i_base_addr = 8'h10; i_word_cnt = 9'd8; i_start = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    check("t7_active_before_rst", {o_busy, o_tx_valid}, 2'b11);
    i_rst_n = 1'b0;
    #1;
    check("t7_rst_outputs", {o_busy, o_done, o_slave_r_ram_ce, o_slave_r_ram_addr, o_tx_valid,
                             o_tx_last, o_tx_data, o_checksum}, 64'd0);
    @(posedge i_clk); #1;
    check("t7_no_done_in_rst", o_done, 0);
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;
    run_frame(8'h10, 9'd2, -1, -1, -1);
    check("t7_beats", bdata.size(), 2);
    check("t7_data", {bdata[0], bdata[1]}, {32'd1, 32'd2});
    check("t7_done_cycle", done_rel, 5);
    check("t7_checksum", o_checksum, 32'd3);

    // Checksum wraps mod 2^32
    run_frame(8'h30, 9'd2, -1, -1, -1);
    check("t8_beats", bdata.size(), 2);
    check("t8_checksum", o_checksum, 32'h0000_0001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
